tmds_gearbox: RTL and testbench
===============================

TMDS_GEARBOX -- requirements
Module: tmds_gearbox

Interface
REQ-001 Parameter CH, default 3, number of TMDS data channels.
REQ-002 Parameter SYM_W, default 10, parallel symbol width per channel.
REQ-003 Parameter OUT_W, default 2, output slice width per channel; SYM_W SHALL be an integer multiple of OUT_W, and RATIO = SYM_W/OUT_W.
REQ-004 Parameter DEPTH, default 4, input FIFO depth in words; power of two, at least 2.
REQ-005 Parameter IDLE_SYM, default 10'b1101010100, the symbol inserted on underflow (TMDS control C1C0=00).
REQ-006 Ports, one clock; reset is synchronous and active-high:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  advance the serializer.
- sym_valid_i  in  1  input word valid.
- sym_ready_o  out  1  FIFO can accept a word.
- sym_data_i  in  CH*SYM_W  channel k at bits [k*SYM_W +: SYM_W].
- ser_data_o  out  CH*OUT_W  channel k slice at bits [k*OUT_W +: OUT_W].
- phase_o  out  1  high when ser_data_o carries slice 0 of a symbol.
- underflow_o  out  1  one-cycle pulse when IDLE_SYM is loaded.
- underflow_cnt_o  out  16  saturating underflow count.

Function
REQ-007 A word SHALL be written into the FIFO on a rising clk_i edge when sym_valid_i and sym_ready_o are both high.
REQ-008 sym_ready_o SHALL equal (count < DEPTH) and SHALL depend only on registered state, never on the same-cycle pop.
REQ-009 Each channel SHALL hold a SYM_W-bit shift register SR, and ser_data_o for that channel SHALL be SR[OUT_W-1:0] (LSB first, registered).
REQ-010 A slot counter SHALL run 0..RATIO-1 and wrap to 0, and phase_o SHALL equal (slot == 0).
REQ-011 On a clock edge with en_i high and slot < RATIO-1, SR SHALL shift right by OUT_W and slot SHALL increment.
REQ-012 On a clock edge with en_i high and slot == RATIO-1, slot SHALL become 0 and SR SHALL load the FIFO head (popping it) if count > 0, otherwise IDLE_SYM on every channel.
REQ-013 An IDLE_SYM load SHALL drive underflow_o high for exactly the following cycle.
REQ-014 With en_i low, slot, SR, ser_data_o and phase_o SHALL hold; FIFO writes SHALL continue; underflow_o SHALL be 0.
REQ-015 On a simultaneous push and pop, count SHALL be unchanged and FIFO order SHALL be preserved.
REQ-016 A word pushed into an empty FIFO at edge t SHALL be loaded at the first load edge strictly after t (no same-edge bypass).
REQ-017 Pointers SHALL wrap modulo DEPTH, and no overflow or underflow of the FIFO storage SHALL occur.

Reset
REQ-018 While rst_i is high at a clock edge, the block SHALL set count=0, pointers=0, slot=0, SR=IDLE_SYM on all channels, underflow_o=0 and underflow_cnt_o=0.
REQ-019 sym_ready_o SHALL be 0 while rst_i is high and 1 on the first cycle after rst_i falls.
REQ-020 A reset mid-symbol or with a non-empty FIFO SHALL discard all buffered words and the partial symbol, and no stale slice SHALL appear after reset.

Configuration
REQ-021 Macro TMDS_GEARBOX_UNDERFLOW_CNT_EN: when defined, underflow_cnt_o SHALL increment on each IDLE_SYM load and saturate at 16'hFFFF; when undefined, the port SHALL be tied to 16'h0000 and no counter logic SHALL exist.

Verification (CH=3, SYM_W=10, OUT_W=2, DEPTH=4)
REQ-022 Release reset with en_i=1 and no input -> each channel outputs 00,01,01,01,11 repeating, phase_o is high every 5th cycle, and underflow_o pulses once per 5 cycles.
REQ-023 Push one word {10'h3FF,10'h000,10'h155} -> after the current idle symbol, the channels output 11 x5, 00 x5 and 01 x5 respectively, with no underflow_o in that symbol period.
REQ-024 With en_i=0, push 6 back-to-back words -> 4 accepted, sym_ready_o=0 after the 4th; set en_i=1 -> the 4 words emerge in order, and sym_ready_o rises the cycle after the first pop.
REQ-025 Assert rst_i at slot 2 with 3 words buffered -> after release, output is the idle pattern starting at slot 0, and the buffered words never appear.
REQ-026 With the macro defined, run 70000 idle symbols -> underflow_cnt_o=16'hFFFF and stays there; without the macro, underflow_cnt_o stays 0.

Source files
------------

// File: rtl/tmds_gearbox.sv
// TMDS gearbox: buffers CH-channel parallel symbols in a small FIFO and serializes them
// LSB-first in OUT_W-bit slices. Optional macro: TMDS_GEARBOX_UNDERFLOW_CNT_EN.
module tmds_gearbox #(
    parameter int unsigned     CH       = 3,
    parameter int unsigned     SYM_W    = 10,
    parameter int unsigned     OUT_W    = 2,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [SYM_W-1:0] IDLE_SYM = 10'b1101010100
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  sym_valid_i,
    output logic                  sym_ready_o,
    input  logic [CH*SYM_W-1:0]   sym_data_i,
    output logic [CH*OUT_W-1:0]   ser_data_o,
    output logic                  phase_o,
    output logic                  underflow_o,
    output logic [15:0]           underflow_cnt_o
);
    localparam int unsigned RATIO = SYM_W / OUT_W;
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned WW    = CH * SYM_W;

    logic [WW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [WW-1:0] sr_q, sr_d;
    logic          uf_q, uf_d;

    logic push, pop, last, load;

    // Ready is held low in reset so nothing can be written before state is cleared.
    assign sym_ready_o = ~rst_i & (count_q < (PW+1)'(DEPTH));
    assign push        = sym_valid_i & sym_ready_o;
    assign last        = (slot_q == SW'(RATIO - 1));
    assign load        = en_i & last;
    assign pop         = load & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        slot_d   = slot_q;
        sr_d     = sr_q;
        uf_d     = 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        if (load) begin
            slot_d = '0;
            if (pop) begin
                sr_d = mem_q[rd_ptr_q];
            end else begin
                sr_d = {CH{IDLE_SYM}};
                uf_d = 1'b1;
            end
        end else if (en_i) begin
            slot_d = slot_q + SW'(1);
            for (int k = 0; k < CH; k++) begin
                sr_d[k*SYM_W +: SYM_W] = sr_q[k*SYM_W +: SYM_W] >> OUT_W;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slot_q   <= '0;
            sr_q     <= {CH{IDLE_SYM}};
            uf_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            slot_q   <= slot_d;
            sr_q     <= sr_d;
            uf_q     <= uf_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sym_data_i;
        end
    end

    always_comb begin
        ser_data_o = '0;
        for (int k = 0; k < CH; k++) begin
            ser_data_o[k*OUT_W +: OUT_W] = sr_q[k*SYM_W +: OUT_W];
        end
    end

    assign phase_o     = (slot_q == '0);
    assign underflow_o = uf_q;

`ifdef TMDS_GEARBOX_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            uf_cnt_q <= '0;
        end else if (uf_d && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_q <= uf_cnt_q + 16'd1;
        end
    end

    assign underflow_cnt_o = uf_cnt_q;
`else
    assign underflow_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_gearbox.sv
// Bench for tmds_gearbox: vector table plus a timestamped scoreboard of expected symbols,
// checked slice-by-slice by a monitor on the falling edge.
module tb_tmds_gearbox;
    localparam int CH    = 3;
    localparam int SYM_W = 10;
    localparam int OUT_W = 2;
    localparam int DEPTH = 4;
    localparam int RATIO = 5;
    localparam logic [9:0] IDLE = 10'b1101010100;

    typedef struct {
        logic [29:0] word;
        logic [5:0]  sl0;
        logic [5:0]  sl4;
    } vec_t;

    typedef struct {
        logic [29:0] word;
        logic [5:0]  sl0;
        logic [5:0]  sl4;
        time         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        vld = 1'b0;
    logic        rdy;
    logic [29:0] din = '0;
    logic [5:0]  ser;
    logic        ph;
    logic        uf;
    logic [15:0] ufc;

    logic [5:0]  cur_sl0 = '0;
    logic [5:0]  cur_sl4 = '0;

    int n_vec = 0;
    int n_err = 0;

    vec_t tab [6];
    exp_t q [$];

    always #5 clk = ~clk;

    tmds_gearbox #(
        .CH       (CH),
        .SYM_W    (SYM_W),
        .OUT_W    (OUT_W),
        .DEPTH    (DEPTH),
        .IDLE_SYM (IDLE)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .sym_valid_i     (vld),
        .sym_ready_o     (rdy),
        .sym_data_i      (din),
        .ser_data_o      (ser),
        .phase_o         (ph),
        .underflow_o     (uf),
        .underflow_cnt_o (ufc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard push on every accepted handshake, stamped with the edge time.
    logic adv = 1'b0;
    initial forever begin
        @(posedge clk);
        adv = en | rst;
        if (rst) begin
            q.delete();
        end else if (vld && rdy) begin
            q.push_back('{word: din, sl0: cur_sl0, sl4: cur_sl4, t: $time});
        end
    end

    // Monitor: reassemble each symbol from its slices and compare against the scoreboard.
    int          k = 0;
    logic        post_rst = 1'b1;
    logic        want_word;
    exp_t        cur;
    logic [29:0] got;

    task automatic mon_step();
        if (rst) begin
            k = 0;
            post_rst = 1'b1;
            return;
        end
        if (!adv) return;
        check("phase", ph, (k == 0));
        if (k == 0) begin
            // A word is due only if it was pushed strictly before the load edge.
            want_word = !post_rst && (q.size() > 0) && (q[0].t < $time - 5);
            if (want_word) begin
                cur = q.pop_front();
            end else begin
                cur = '{word: {3{IDLE}}, sl0: 6'b000000, sl4: 6'b111111, t: 0};
            end
            check("underflow_pulse", uf, !want_word && !post_rst);
            post_rst = 1'b0;
            check("slice0", ser, cur.sl0);
            got = '0;
        end else begin
            check("underflow_quiet", uf, 1'b0);
        end
        for (int c = 0; c < CH; c++) begin
            got[c*SYM_W + k*OUT_W +: OUT_W] = ser[c*OUT_W +: OUT_W];
        end
        if (k == RATIO - 1) begin
            check("slice4", ser, cur.sl4);
            check("symbol", got, cur.word);
            k = 0;
        end else begin
            k++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon_step();
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int idx);
        logic ok;
        din     = tab[idx].word;
        cur_sl0 = tab[idx].sl0;
        cur_sl4 = tab[idx].sl4;
        vld     = 1'b1;
        ok      = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = rdy;
            tick(1);
        end
        vld = 1'b0;
        check("push_accept", ok, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check("drain", q.size(), 0);
        tick(2 * RATIO);
    endtask

    task automatic check_reset_state();
        check("rst_ready", rdy, 1'b0);
        check("rst_phase", ph, 1'b1);
        check("rst_ser", ser, 6'b000000);
        check("rst_uf", uf, 1'b0);
        check("rst_ufc", ufc, 16'h0000);
    endtask

    initial begin
        logic       ok;
        int         acc;
        logic [5:0] ser_hold;
        logic       ph_hold;
        int         n;

        tab[0] = '{word: {10'h3FF, 10'h000, 10'h155}, sl0: 6'b110001, sl4: 6'b110001};
        tab[1] = '{word: {10'h000, 10'h3FF, 10'h2AA}, sl0: 6'b001110, sl4: 6'b001110};
        tab[2] = '{word: {10'h001, 10'h200, 10'h0F0}, sl0: 6'b010000, sl4: 6'b001000};
        tab[3] = '{word: {10'h123, 10'h3C0, 10'h05A}, sl0: 6'b110010, sl4: 6'b011100};
        tab[4] = '{word: {10'h2AA, 10'h155, 10'h3FF}, sl0: 6'b100111, sl4: 6'b100111};
        tab[5] = '{word: {10'h000, 10'h000, 10'h000}, sl0: 6'b000000, sl4: 6'b000000};

        // Reset, then free-running idle pattern.
        rst = 1'b1;
        en  = 1'b1;
        tick(3);
        check_reset_state();
        rst = 1'b0;
        #1;
        check("ready_after_rst", rdy, 1'b1);
        tick(3 * RATIO + 2);

        // Single word between idle symbols.
        push_word(0);
        drain();

        // Table vectors with random gaps.
        for (int i = 0; i < 6; i++) begin
            push_word(i);
            tick($urandom_range(0, 8));
        end
        drain();

        // Back-to-back burst with the serializer stalled.
        en       = 1'b0;
        tick(1);
        ser_hold = ser;
        ph_hold  = ph;
        acc      = 0;
        vld      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din     = tab[i].word;
            cur_sl0 = tab[i].sl0;
            cur_sl4 = tab[i].sl4;
            ok      = rdy;
            tick(1);
            if (ok) acc++;
        end
        vld = 1'b0;
        check("burst_accepted", acc, 4);
        check("burst_ready_low", rdy, 1'b0);
        check("hold_ser", ser, ser_hold);
        check("hold_phase", ph, ph_hold);
        en = 1'b1;
        n  = 0;
        while (!rdy && n < 12) begin
            tick(1);
            n++;
        end
        check("ready_rise", rdy, 1'b1);
        check("ready_rise_at_pop", ph, 1'b1);
        drain();

        // Reset at slot 2 with three words still buffered.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(i + 1);
        end
        en = 1'b1;
        n  = 0;
        while (!ph && n < 12) begin
            tick(1);
            n++;
        end
        check("first_pop_phase", ph, 1'b1);
        tick(2);
        rst = 1'b1;
        tick(2);
        check_reset_state();
        rst = 1'b0;
        #1;
        check("ready_after_rst2", rdy, 1'b1);
        tick(4 * RATIO + 1);
        check("no_stale_words", q.size(), 0);

`ifdef TMDS_GEARBOX_UNDERFLOW_CNT_EN
        tick(70000 * RATIO);
        check("ufc_saturated", ufc, 16'hFFFF);
        tick(3 * RATIO);
        check("ufc_stays", ufc, 16'hFFFF);
`else
        tick(20 * RATIO);
        check("ufc_tied_zero", ufc, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
